wb_intc: RTL

Wishbone slave interrupt controller that sits directly upstream of the multi-cycle CPU's `INT`/`Cause_in` inputs. It replaces the hard-wired OR/priority chain at the top level with a latched, maskable, software-acknowledged interrupt source. Device interrupt lines from RAM, disk, VRAM, keyboard, counter and switch are synchronised, edge-detected and held pending. The block drives one interrupt request plus a 32-bit cause code; the kernel reads, masks and clears sources over the bus.

---
 rtl/wb_intc.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wb_intc.sv
// rtl/wb_intc.sv - Wishbone interrupt controller: synchronised, edge-latched, maskable sources with priority cause.
// Optional WB_INTC_LEVEL_EN adds a per-source LEVEL register (addr 3) for level-sensitive sources.
module wb_intc #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  input  logic [N_SRC-1:0] irq_in,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  localparam int PAD = 32 - N_SRC;

  logic [N_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] active_c, rise_c, set_c, w1c_c, level_rd_c;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [31:0]      cause_c;
  logic             access_c, wr_c;
  logic [1:0]       sel_c;
  logic             unused_bits;

  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I[31:N_SRC]};

  assign access_c = STB & ~ack_q;
  assign wr_c     = access_c & WE;
  assign sel_c    = ADDR[3:2];
  assign rise_c   = sync2_q & ~prev_q;

`ifdef WB_INTC_LEVEL_EN
  logic [N_SRC-1:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (wr_c && sel_c == 2'd3) level_d = DAT_I[N_SRC-1:0];
  end

  always_ff @(posedge clk) begin
    if (!RSTN) level_q <= '0;
    else       level_q <= level_d;
  end

  // A held level source re-asserts pending every cycle, defeating W1C.
  assign set_c      = rise_c | (level_q & sync2_q);
  assign level_rd_c = level_d;
`else
  assign set_c      = rise_c;
  assign level_rd_c = '0;
`endif

  always_comb begin
    w1c_c  = '0;
    mask_d = mask_q;
    if (wr_c && sel_c == 2'd0) w1c_c  = DAT_I[N_SRC-1:0];
    if (wr_c && sel_c == 2'd1) mask_d = DAT_I[N_SRC-1:0];
    // Set after clear so a rise coinciding with W1C keeps the bit.
    pending_d = (pending_q & ~w1c_c) | set_c;
  end

  assign active_c = pending_q & mask_q;

  always_comb begin
    cause_c = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active_c[i]) cause_c = 32'(i);
    end
  end

  assign INT   = |active_c;
  assign CAUSE = cause_c;

  // Read data reflects post-write state so a write returns what was stored.
  always_comb begin
    dat_d = dat_q;
    if (access_c) begin
      case (sel_c)
        2'd0:    dat_d = {{PAD{1'b0}}, pending_d};
        2'd1:    dat_d = {{PAD{1'b0}}, mask_d};
        2'd2:    dat_d = cause_c;
        default: dat_d = {{PAD{1'b0}}, level_rd_c};
      endcase
    end
  end

  always_comb begin
    ack_d = ack_q;
    if (access_c)  ack_d = 1'b1;
    else if (!STB) ack_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      sync1_q   <= irq_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  assign ACK   = ack_q;
  assign DAT_O = dat_q;

endmodule
